dac_stream_ctrl: RTL and testbench
==================================

// Module: dac_stream_ctrl
// PURPOSE
//  Sequences the sample stream into the PWM DAC. Buffers samples from a valid/ready producer
//  and presents one code per PWM window on each next_sample pulse. Ramps the DAC code between
//  0 and midscale on start/stop to avoid clicks. Counts underruns. Sits between the audio
//  source (tone generator or host stream) and the dac instance.
// PARAMETERS
//  CYCLES_PER_WINDOW  1024                        PWM window length; must match the dac instance
//  CODE_WIDTH         $clog2(CYCLES_PER_WINDOW)   sample/code width
//  FIFO_DEPTH         4                           sample buffer entries; power of 2, >=2
//  RAMP_STEP          8                           code change per window while ramping; >=1
// PORTS
//  clk             in   1           system clock
//  rst             in   1           asynchronous, active-high reset
//  enable          in   1           level; 1 = play, 0 = stop
//  s_data          in   CODE_WIDTH  input sample
//  s_valid         in   1           s_data valid
//  s_ready         out  1           sample accepted on a cycle where s_valid && s_ready
//  next_sample     in   1           1-cycle pulse from the dac, once per window
//  code            out  CODE_WIDTH  registered code driven to the dac
//  active          out  1           1 in any state other than IDLE
//  state           out  2           0=IDLE 1=RAMP_UP 2=PLAY 3=RAMP_DOWN
//  underrun_count  out  16          saturating count of empty-FIFO pops in PLAY
// BEHAVIOUR
//  - Reset (async, any time, including mid-ramp): state=IDLE, code=0, FIFO empty,
//    underrun_count=0, s_ready=0. Reset release is synchronous to clk.
//  - code is a register. It changes only on a clk edge where next_sample=1, except on reset
//    and on the stop-to-IDLE rules below. Latency: pulse edge -> new code on the same edge.
//  - s_ready = !full && (state==RAMP_UP || state==PLAY). No push when full. No bypass: a push
//    and a pop in the same cycle on an empty FIFO counts as an underrun; the pushed word is
//    stored. Push and pop in the same cycle on a non-empty, non-full FIFO are both honoured.
//  - MID = 2**(CODE_WIDTH-1). Ramp arithmetic uses unsigned CODE_WIDTH+1 bits.
//    The step is clamped so code never overshoots its target.
//  - IDLE: code=0. enable=1 -> RAMP_UP on the next edge.
//  - RAMP_UP: on each pulse, code <= min(code+RAMP_STEP, MID). When code==MID on a pulse
//    edge -> PLAY; the first FIFO pop happens on the next pulse. The FIFO fills during this
//    state. enable=0 -> RAMP_DOWN.
//  - PLAY: on each pulse, if the FIFO is non-empty, pop and code <= head. If empty, hold code
//    and increment underrun_count, saturating at 16'hFFFF. enable=0 -> RAMP_DOWN; the FIFO is
//    flushed on that transition edge.
//  - RAMP_DOWN: on each pulse, code <= (code>RAMP_STEP) ? code-RAMP_STEP : 0. When code==0
//    -> IDLE. If code is already 0 on entry, go to IDLE on the next edge without waiting
//    for a pulse. enable=1 during RAMP_DOWN is ignored until IDLE is reached.
//  - If enable toggles and a pulse arrive in the same cycle, the state transition and the
//    code update for the current state both take effect on that edge.
//  - underrun_count holds its value across stop/start and clears only on reset.
// STRUCTURE
//  - Shared header dac_pkg.vh: state encodings ST_IDLE/ST_RAMP_UP/ST_PLAY/ST_RAMP_DOWN and
//    the MID macro. Include it in both the RTL and the bench.
//  - One sub-module, sync_fifo (WIDTH, DEPTH; push/pop/flush, full/empty, head word).
//    Async reset, synchronous flush.
//  - The top level holds the FSM, the code register, ramp arithmetic and the underrun counter.
// TESTING  (CODE_WIDTH=10, MID=512, RAMP_STEP=8, FIFO_DEPTH=4, dac instance in the loop)
//  1 Reset, enable=1, no samples -> code steps 0,8,...,512 over 64 pulses, then state=PLAY.
//    Then underrun_count increments by 1 per pulse and code holds at 512.
//  2 PLAY, push 100,200,300 -> code = 100,200,300 on successive pulses.
//    No sample is lost or repeated.
//  3 Producer always valid, PLAY -> s_ready drops when 4 entries are held. One push per
//    window thereafter; underrun_count stays unchanged.
//  4 PLAY with code=20, enable=0 -> code 12,4,0, state=IDLE, FIFO flushed, s_ready=0.
//  5 RAMP_UP at code=40, enable=0 -> RAMP_DOWN: code 32,...,0, then IDLE.
//    enable=1 re-asserted during RAMP_DOWN is ignored until IDLE.
//  6 Assert rst mid-RAMP_UP between clk edges -> code=0, state=0 and underrun_count=0
//    immediately, with no clk edge.

Source files
------------

// File: rtl/dac_stream_ctrl_pkg.sv
// Package for the DAC stream controller.
// Holds the FSM state type, built on the shared encodings so the state port
// and the bench agree on the numbering, plus the underrun counter ceiling.
`include "rtl/dac_pkg.vh"

package dac_stream_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE      = `ST_IDLE,
        S_RAMP_UP   = `ST_RAMP_UP,
        S_PLAY      = `ST_PLAY,
        S_RAMP_DOWN = `ST_RAMP_DOWN
    } dac_state_t;

    localparam logic [15:0] UNDERRUN_MAX = 16'hFFFF;

endpackage

// File: rtl/dac_pkg.vh
// Shared definitions for the DAC stream controller and its bench.
// Provides the 2-bit state encodings reported on the state port and the
// midscale macro, which is parameterised by the code width.
`ifndef DAC_PKG_VH
`define DAC_PKG_VH

`define ST_IDLE      2'd0
`define ST_RAMP_UP   2'd1
`define ST_PLAY      2'd2
`define ST_RAMP_DOWN 2'd3

// Midscale code for a given code width: 2**(cw-1)
`define MID(cw) (2 ** ((cw) - 1))

`endif

// File: rtl/dac_stream_ctrl_sync_fifo.sv
// sync_fifo: single-clock sample buffer.
// Ports:
//   i_clk, i_rst  clock, asynchronous active-high reset
//   i_push        write i_data (ignored while full)
//   i_pop         drop the head entry (ignored while empty)
//   i_flush       synchronous empty; overrides push/pop on the same edge
//   i_data        word to write
//   o_full        DEPTH entries held
//   o_empty       no entries held
//   o_head        oldest entry (valid only when !o_empty)
module sync_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic             i_flush,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_head
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    // One extra pointer bit separates full from empty when the indices match
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_head    = r_mem[r_rd_ptr[AW-1:0]];

    // Pointer update: flush empties the buffer, otherwise advance on accepted push/pop
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
            end
        end
    end

    // Storage write; contents need no reset since the pointers gate visibility
    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_data;
        end
    end

endmodule

// File: rtl/dac_stream_ctrl.sv
// dac_stream_ctrl: feeds one sample code per PWM window to the DAC.
// Buffers samples from a valid/ready producer, ramps the code between 0 and
// midscale on start/stop to avoid clicks, and counts empty-buffer windows.
// Ports:
//   i_clk, i_rst        clock, asynchronous active-high reset
//   i_enable            level: 1 = play, 0 = stop
//   i_s_data/i_s_valid  producer sample and its valid
//   o_s_ready           sample accepted when i_s_valid && o_s_ready
//   i_next_sample       one-cycle pulse per PWM window from the DAC
//   o_code              registered code to the DAC
//   o_active            1 whenever not IDLE
//   o_state             0=IDLE 1=RAMP_UP 2=PLAY 3=RAMP_DOWN
//   o_underrun_count    saturating count of PLAY windows with an empty buffer
module dac_stream_ctrl
    import dac_stream_ctrl_pkg::*;
#(
    parameter int CYCLES_PER_WINDOW = 1024,
    parameter int CODE_WIDTH        = $clog2(CYCLES_PER_WINDOW),
    parameter int FIFO_DEPTH        = 4,
    parameter int RAMP_STEP         = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_enable,
    input  logic [CODE_WIDTH-1:0] i_s_data,
    input  logic                  i_s_valid,
    output logic                  o_s_ready,
    input  logic                  i_next_sample,
    output logic [CODE_WIDTH-1:0] o_code,
    output logic                  o_active,
    output logic [1:0]            o_state,
    output logic [15:0]           o_underrun_count
);

    localparam logic [CODE_WIDTH:0] MID_W  = (CODE_WIDTH+1)'(`MID(CODE_WIDTH));
    localparam logic [CODE_WIDTH:0] STEP_W = (CODE_WIDTH+1)'(RAMP_STEP);

    dac_state_t            r_state;
    logic [CODE_WIDTH-1:0] r_code;
    logic                  r_active;
    logic [15:0]           r_underrun;

    logic                  w_fifo_full;
    logic                  w_fifo_empty;
    logic [CODE_WIDTH-1:0] w_fifo_head;
    logic                  w_fifo_push;
    logic                  w_fifo_pop;
    logic                  w_fifo_flush;
    logic                  w_underrun_inc;
    logic [CODE_WIDTH:0]   w_up_sum;
    logic [CODE_WIDTH-1:0] w_up_next;
    logic [CODE_WIDTH-1:0] w_dn_next;

    assign o_s_ready   = !w_fifo_full && ((r_state == S_RAMP_UP) || (r_state == S_PLAY));
    assign w_fifo_push = i_s_valid && o_s_ready;

    assign o_code           = r_code;
    assign o_active         = r_active;
    assign o_state          = r_state;
    assign o_underrun_count = r_underrun;

    sync_fifo #(
        .WIDTH (CODE_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (w_fifo_push),
        .i_pop   (w_fifo_pop),
        .i_flush (w_fifo_flush),
        .i_data  (i_s_data),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_head  (w_fifo_head)
    );

    // Ramp arithmetic in one extra bit so the up-step cannot wrap before clamping
    always_comb begin
        w_up_sum  = {1'b0, r_code} + STEP_W;
        if (w_up_sum > MID_W) begin
            w_up_next = MID_W[CODE_WIDTH-1:0];
        end else begin
            w_up_next = w_up_sum[CODE_WIDTH-1:0];
        end
        if ({1'b0, r_code} > STEP_W) begin
            w_dn_next = r_code - STEP_W[CODE_WIDTH-1:0];
        end else begin
            w_dn_next = '0;
        end
    end

    // Buffer control: pop or flag underrun on a PLAY pulse; flush when stopping
    always_comb begin
        w_fifo_pop     = 1'b0;
        w_underrun_inc = 1'b0;
        w_fifo_flush   = 1'b0;
        if ((r_state == S_PLAY) && i_next_sample) begin
            if (!w_fifo_empty) begin
                w_fifo_pop = 1'b1;
            end else begin
                w_underrun_inc = 1'b1;
            end
        end else begin
            w_fifo_pop = 1'b0;
        end
        // Stale samples buffered during a ramp-up are dropped as well
        if (((r_state == S_PLAY) || (r_state == S_RAMP_UP)) && !i_enable) begin
            w_fifo_flush = 1'b1;
        end else begin
            w_fifo_flush = 1'b0;
        end
    end

    // Control FSM with the code register and underrun counter
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_code     <= '0;
            r_active   <= 1'b0;
            r_underrun <= 16'd0;
        end else begin
            if (w_underrun_inc && (r_underrun != UNDERRUN_MAX)) begin
                r_underrun <= r_underrun + 16'd1;
            end
            case (r_state)
                S_IDLE: begin
                    r_code <= '0;
                    if (i_enable) begin
                        r_state  <= S_RAMP_UP;
                        r_active <= 1'b1;
                    end
                end
                S_RAMP_UP: begin
                    if (i_next_sample) begin
                        r_code <= w_up_next;
                    end
                    // Stop has priority; the pulse's code step still lands this edge
                    if (!i_enable) begin
                        r_state <= S_RAMP_DOWN;
                    end else if (i_next_sample && ({1'b0, w_up_next} == MID_W)) begin
                        r_state <= S_PLAY;
                    end
                end
                S_PLAY: begin
                    if (i_next_sample && !w_fifo_empty) begin
                        r_code <= w_fifo_head;
                    end
                    if (!i_enable) begin
                        r_state <= S_RAMP_DOWN;
                    end
                end
                S_RAMP_DOWN: begin
                    // Already silent on entry: leave without waiting for a window
                    if (r_code == '0) begin
                        r_state  <= S_IDLE;
                        r_active <= 1'b0;
                    end else if (i_next_sample) begin
                        r_code <= w_dn_next;
                        if (w_dn_next == '0) begin
                            r_state  <= S_IDLE;
                            r_active <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_code   <= '0;
                    r_active <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dac_stream_ctrl.sv
// Directed bench for dac_stream_ctrl: CODE_WIDTH=10, MID=512, RAMP_STEP=8, depth 4.
// Inputs change 1 ns after a rising edge; outputs are sampled at the same point.
`include "rtl/dac_pkg.vh"

module tb_dac_stream_ctrl;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_enable;
    logic [9:0]  i_s_data;
    logic        i_s_valid;
    logic        o_s_ready;
    logic        i_next_sample;
    logic [9:0]  o_code;
    logic        o_active;
    logic [1:0]  o_state;
    logic [15:0] o_underrun_count;

    int n_checks = 0;
    int n_errors = 0;

    dac_stream_ctrl #(
        .CYCLES_PER_WINDOW (1024),
        .FIFO_DEPTH        (4),
        .RAMP_STEP         (8)
    ) dut (
        .i_clk            (i_clk),
        .i_rst            (i_rst),
        .i_enable         (i_enable),
        .i_s_data         (i_s_data),
        .i_s_valid        (i_s_valid),
        .o_s_ready        (o_s_ready),
        .i_next_sample    (i_next_sample),
        .o_code           (o_code),
        .o_active         (o_active),
        .o_state          (o_state),
        .o_underrun_count (o_underrun_count)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic        valid;
        logic [9:0]  data;
        logic        pulse;
        logic [9:0]  exp_code;
        logic [15:0] exp_und;
        logic        exp_ready;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input logic pulse);
        i_next_sample = pulse;
        @(posedge i_clk);
        #1;
        i_next_sample = 1'b0;
    endtask

    task automatic ramp_to_play(input string tag);
        for (int k = 1; k <= 64; k++) begin
            tick(1'b1);
            check({tag, " ramp code"}, 32'(o_code), 32'(8 * k));
            if (k == 63) check({tag, " still ramping"}, 32'(o_state), 32'(`ST_RAMP_UP));
        end
        check({tag, " reached play"}, 32'(o_state), 32'(`ST_PLAY));
    endtask

    initial begin
        logic [9:0] next_data;
        logic       rdy;

        vecs[0] = '{1'b1, 10'd100, 1'b0, 10'd512, 16'd3, 1'b1};
        vecs[1] = '{1'b1, 10'd200, 1'b0, 10'd512, 16'd3, 1'b1};
        vecs[2] = '{1'b1, 10'd300, 1'b0, 10'd512, 16'd3, 1'b1};
        vecs[3] = '{1'b0, 10'd0,   1'b1, 10'd100, 16'd3, 1'b1};
        vecs[4] = '{1'b0, 10'd0,   1'b1, 10'd200, 16'd3, 1'b1};
        vecs[5] = '{1'b1, 10'd400, 1'b1, 10'd300, 16'd3, 1'b1};
        vecs[6] = '{1'b0, 10'd0,   1'b1, 10'd400, 16'd3, 1'b1};
        vecs[7] = '{1'b0, 10'd0,   1'b1, 10'd400, 16'd4, 1'b1};
        vecs[8] = '{1'b1, 10'd55,  1'b1, 10'd400, 16'd5, 1'b1};
        vecs[9] = '{1'b0, 10'd0,   1'b1, 10'd55,  16'd5, 1'b1};

        i_rst = 1'b1; i_enable = 1'b0; i_s_data = 10'd0; i_s_valid = 1'b0; i_next_sample = 1'b0;
        repeat (3) @(posedge i_clk);
        #1;
        check("reset code", 32'(o_code), 32'd0);
        check("reset state", 32'(o_state), 32'(`ST_IDLE));
        check("reset ready", 32'(o_s_ready), 32'd0);
        check("reset underrun", 32'(o_underrun_count), 32'd0);
        check("reset active", 32'(o_active), 32'd0);
        i_rst = 1'b0;

        // 1: ramp up with no samples, then underruns
        i_enable = 1'b1;
        tick(1'b0);
        check("t1 state ramp_up", 32'(o_state), 32'(`ST_RAMP_UP));
        check("t1 active", 32'(o_active), 32'd1);
        check("t1 ready", 32'(o_s_ready), 32'd1);
        ramp_to_play("t1");
        for (int k = 1; k <= 3; k++) begin
            tick(1'b1);
            check("t1 underrun", 32'(o_underrun_count), 32'(k));
            check("t1 code hold", 32'(o_code), 32'd512);
        end

        // 2: sample ordering, simultaneous push/pop, empty push+pop underrun
        for (int i = 0; i < 10; i++) begin
            i_s_valid = vecs[i].valid;
            i_s_data  = vecs[i].data;
            tick(vecs[i].pulse);
            check($sformatf("t2[%0d] code", i), 32'(o_code), 32'(vecs[i].exp_code));
            check($sformatf("t2[%0d] underrun", i), 32'(o_underrun_count), 32'(vecs[i].exp_und));
            check($sformatf("t2[%0d] ready", i), 32'(o_s_ready), 32'(vecs[i].exp_ready));
            check($sformatf("t2[%0d] state", i), 32'(o_state), 32'(`ST_PLAY));
        end

        // 3: always-valid producer fills the buffer, then one push per window
        next_data = 10'd1;
        i_s_valid = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            i_s_data = next_data;
            rdy = o_s_ready;
            tick(1'b0);
            if (rdy) next_data = next_data + 10'd1;
            check($sformatf("t3 fill ready %0d", i), 32'(o_s_ready), (i < 4) ? 32'd1 : 32'd0);
        end
        for (int w = 1; w <= 3; w++) begin
            i_s_data = next_data;
            rdy = o_s_ready;
            tick(1'b1);
            if (rdy) next_data = next_data + 10'd1;
            check($sformatf("t3 win%0d code", w), 32'(o_code), 32'(w));
            check($sformatf("t3 win%0d ready", w), 32'(o_s_ready), 32'd1);
            i_s_data = next_data;
            rdy = o_s_ready;
            tick(1'b0);
            if (rdy) next_data = next_data + 10'd1;
            check($sformatf("t3 win%0d full", w), 32'(o_s_ready), 32'd0);
            check($sformatf("t3 win%0d underrun", w), 32'(o_underrun_count), 32'd5);
        end
        i_s_valid = 1'b0;

        // 4: drain 4..7, play 20 with 99 left behind, stop and ramp down
        for (int k = 4; k <= 7; k++) begin
            tick(1'b1);
            check("t4 drain code", 32'(o_code), 32'(k));
        end
        i_s_valid = 1'b1; i_s_data = 10'd20; tick(1'b0);
        i_s_data = 10'd99; tick(1'b0);
        i_s_valid = 1'b0;
        tick(1'b1);
        check("t4 code 20", 32'(o_code), 32'd20);
        i_enable = 1'b0;
        tick(1'b0);
        check("t4 state ramp_down", 32'(o_state), 32'(`ST_RAMP_DOWN));
        check("t4 code held", 32'(o_code), 32'd20);
        check("t4 ready off", 32'(o_s_ready), 32'd0);
        tick(1'b1); check("t4 code 12", 32'(o_code), 32'd12);
        tick(1'b1); check("t4 code 4", 32'(o_code), 32'd4);
        tick(1'b1); check("t4 code 0", 32'(o_code), 32'd0);
        check("t4 idle", 32'(o_state), 32'(`ST_IDLE));
        check("t4 inactive", 32'(o_active), 32'd0);
        check("t4 idle ready", 32'(o_s_ready), 32'd0);
        // Restart: a flushed buffer underruns instead of replaying 99
        i_enable = 1'b1;
        tick(1'b0);
        ramp_to_play("t4r");
        tick(1'b1);
        check("t4 flushed code", 32'(o_code), 32'd512);
        check("t4 flushed underrun", 32'(o_underrun_count), 32'd6);

        // 5: full ramp down from 512, then stop at 40 with enable re-asserted
        i_enable = 1'b0;
        tick(1'b0);
        for (int k = 1; k <= 64; k++) tick(1'b1);
        check("t5 down to 0", 32'(o_code), 32'd0);
        check("t5 idle", 32'(o_state), 32'(`ST_IDLE));
        i_enable = 1'b1;
        tick(1'b0);
        for (int k = 0; k < 5; k++) tick(1'b1);
        check("t5 code 40", 32'(o_code), 32'd40);
        i_enable = 1'b0;
        tick(1'b0);
        check("t5 ramp_down", 32'(o_state), 32'(`ST_RAMP_DOWN));
        i_enable = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick(1'b1);
            check("t5 down code", 32'(o_code), 32'(40 - 8 * k));
            check("t5 down state", 32'(o_state), (k < 5) ? 32'(`ST_RAMP_DOWN) : 32'(`ST_IDLE));
        end
        tick(1'b0);
        check("t5 restart", 32'(o_state), 32'(`ST_RAMP_UP));
        tick(1'b1);
        check("t5 code 8", 32'(o_code), 32'd8);
        // Stop and pulse on the same edge: step up and leave RAMP_UP together
        i_enable = 1'b0;
        tick(1'b1);
        check("t5 same-edge code", 32'(o_code), 32'd16);
        check("t5 same-edge state", 32'(o_state), 32'(`ST_RAMP_DOWN));
        tick(1'b1); check("t5 code 8 down", 32'(o_code), 32'd8);
        tick(1'b1); check("t5 code 0 down", 32'(o_code), 32'd0);
        check("t5 idle again", 32'(o_state), 32'(`ST_IDLE));
        // Stop at code 0: RAMP_DOWN exits without a pulse
        i_enable = 1'b1; tick(1'b0);
        i_enable = 1'b0; tick(1'b0);
        check("t5 zero entry", 32'(o_state), 32'(`ST_RAMP_DOWN));
        tick(1'b0);
        check("t5 zero exit", 32'(o_state), 32'(`ST_IDLE));

        // 6: asynchronous reset between edges mid-ramp
        i_enable = 1'b1;
        tick(1'b0);
        for (int k = 0; k < 3; k++) tick(1'b1);
        check("t6 pre code", 32'(o_code), 32'd24);
        check("t6 pre underrun", 32'(o_underrun_count), 32'd6);
        #2;
        i_rst = 1'b1;
        #1;
        check("t6 async code", 32'(o_code), 32'd0);
        check("t6 async state", 32'(o_state), 32'(`ST_IDLE));
        check("t6 async underrun", 32'(o_underrun_count), 32'd0);
        check("t6 async ready", 32'(o_s_ready), 32'd0);
        check("t6 async active", 32'(o_active), 32'd0);
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
